// File: rtl/fpu_pkg.sv
// Shared FPU definitions: fflags bit positions, the canonical NaN and the
// IEEE-754 single-precision classification helpers.
package fpu_pkg;

  // fflags bit positions inside {NV,DZ,OF,UF,NX}
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Signalling NaN: quiet bit (mantissa MSB) clear
  function automatic logic is_snan(input logic [31:0] x);
    return is_nan(x) && (x[22] == 1'b0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Synchronous FIFO with a registered head output.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, din     write an entry (ignored when full)
//   pop           retire the head (ignored when empty)
//   full, empty   occupancy status, decoded from the registered count
//   dout          head entry, registered; zero after reset
module fpu_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_next_s;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_s, pop_s;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == {CNT_W{1'b0}});
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign dout   = dout_q;

  // Next-state for pointers, occupancy and the registered head
  always_comb begin
    rd_next_s = rd_ptr_q + PTR_W'(1);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dout_d    = dout_q;

    // Pointers wrap naturally since DEPTH is a power of two
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_next_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s && !pop_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_s && pop_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end

    // The incoming entry becomes the head directly when nothing older
    // will remain after this cycle; otherwise the head advances from storage.
    if (push_s && ((count_q == {CNT_W{1'b0}}) ||
                   (pop_s && (count_q == CNT_W'(1))))) begin
      dout_d = din;
    end else if (pop_s) begin
      dout_d = mem_q[rd_next_s];
    end else begin
      dout_d = dout_q;
    end
  end

  // FIFO state registers and storage
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      dout_q   <= {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= din;
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_writeback.sv
// Writeback stage behind the combinational FP add/sub unit. Repairs the
// special cases the adder zeroes (NaN, Inf, signed-zero cancellation),
// derives fflags into a sticky register and queues results for the FP
// register-file write port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake (in_ready = FIFO not full)
//   in_rd, in_a, in_b        destination and original operands
//   in_sub, in_result, in_exc requested op, raw adder result, adder exception
//   wb_valid/wb_ready        register-file handshake on the FIFO head
//   wb_rd, wb_data           head destination and corrected result
//   fflags, fflags_clr       sticky {NV,DZ,OF,UF,NX} and its clear
module fpu_addsub_writeback
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RD_W  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RD_W-1:0] in_rd,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic            in_sub,
  input  logic [31:0]     in_result,
  input  logic            in_exc,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic [4:0]      fflags,
  input  logic            fflags_clr
);

  localparam int unsigned ENT_W = RD_W + 32;

  logic             eff_sub_s;
  logic             b_sign_s;
  logic [31:0]      fix_data_s;
  logic [4:0]       new_flags_s;
  logic [4:0]       fflags_q, fflags_d;
  logic             push_s, pop_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [ENT_W-1:0] head_s;

  assign eff_sub_s = in_sub ^ in_a[31] ^ in_b[31];
  assign b_sign_s  = in_b[31] ^ in_sub;

  assign in_ready = ~fifo_full_s;
  assign wb_valid = ~fifo_empty_s;
  assign push_s   = in_valid & in_ready;
  assign pop_s    = wb_valid & wb_ready;
  assign wb_rd    = head_s[ENT_W-1:32];
  assign wb_data  = head_s[31:0];
  assign fflags   = fflags_q;

  // Special-case repair of the adder result, in priority order
  always_comb begin
    fix_data_s  = in_result;
    new_flags_s = 5'b00000;
    if (is_nan(in_a) || is_nan(in_b)) begin
      fix_data_s = CANON_NAN;
      if (is_snan(in_a) || is_snan(in_b)) begin
        new_flags_s[FLAG_NV] = 1'b1;
      end else begin
        new_flags_s = 5'b00000;
      end
    end else if (is_inf(in_a) && is_inf(in_b) && eff_sub_s) begin
      fix_data_s           = CANON_NAN;
      new_flags_s[FLAG_NV] = 1'b1;
    end else if (is_inf(in_a)) begin
      fix_data_s = in_a;
    end else if (is_inf(in_b)) begin
      fix_data_s = {b_sign_s, 31'h7F80_0000};
    end else if (!in_exc && (in_result[30:23] == 8'hFF)) begin
      fix_data_s           = {in_result[31], 31'h7F80_0000};
      new_flags_s[FLAG_OF] = 1'b1;
      new_flags_s[FLAG_NX] = 1'b1;
    end else if (!in_exc && (in_result[30:0] == 31'd0) && eff_sub_s) begin
      // Exact cancellation rounds to +0 under RNE
      fix_data_s = 32'h0000_0000;
    end else begin
      fix_data_s  = in_result;
      new_flags_s = 5'b00000;
    end
  end

  // Sticky flags: clear first, so flags from a same-cycle push survive
  always_comb begin
    fflags_d = fflags_q;
    if (fflags_clr) begin
      fflags_d = 5'b00000;
    end else begin
      fflags_d = fflags_q;
    end
    if (push_s) begin
      fflags_d = fflags_d | new_flags_s;
    end else begin
      fflags_d = fflags_d;
    end
  end

  // Sticky flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags_q <= 5'b00000;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  fpu_wb_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENT_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .pop  (pop_s),
    .din  ({in_rd, fix_data_s}),
    .full (fifo_full_s),
    .empty(fifo_empty_s),
    .dout (head_s)
  );

endmodule
